// File: rtl/spi_wb_arbiter.sv
// Two-master Wishbone-classic arbiter in front of the spi slave port.
// Round-robin grant with per-master lock for multi-register sequences.
// Optional macro SPI_ARB_TIMEOUT_EN: forces termination of a strobe that
// stays unacknowledged for TIMEOUT cycles (ack with all-ones read data).
module spi_wb_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:2]  m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_lock_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic [3:2]  m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_lock_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic [3:2]  spi_adr_o,
    output logic [3:0]  spi_sel_o,
    output logic        spi_stb_o,
    output logic        spi_we_o,
    output logic [31:0] spi_dat_o,
    input  logic [31:0] spi_dat_i,
    input  logic        spi_ack_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t state, state_nxt;
    logic   prio, prio_nxt;
    logic   tmo;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("spi_wb_arbiter: TIMEOUT must be at least 2");
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    assign tmo = (state != IDLE) && (cnt == CW'(TIMEOUT));

    // Count strobed-but-unacknowledged cycles of the current grant
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt <= '0;
        else if (state_nxt == IDLE || spi_ack_i)
            cnt <= '0;
        else if (spi_stb_o)
            cnt <= cnt + CW'(1);
    end
`else
    assign tmo = 1'b0;
`endif

    // State and round-robin pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    // Arbitration and release decisions
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        case (state)
            IDLE: begin
                if (m0_stb_i && (!m1_stb_i || !prio))
                    state_nxt = G0;
                else if (m1_stb_i)
                    state_nxt = G1;
            end
            G0: begin
                if (tmo || (!m0_lock_i && (spi_ack_i || !m0_stb_i))) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b1;
                end
            end
            G1: begin
                if (tmo || (!m1_lock_i && (spi_ack_i || !m1_stb_i))) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Route the granted master to the slave and the slave response back
    always_comb begin
        spi_adr_o = '0;
        spi_sel_o = '0;
        spi_stb_o = 1'b0;
        spi_we_o  = 1'b0;
        spi_dat_o = '0;
        m0_ack_o  = 1'b0;
        m0_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_dat_o  = '0;
        case (state)
            G0: begin
                spi_adr_o = m0_adr_i;
                spi_sel_o = m0_sel_i;
                spi_stb_o = m0_stb_i && !tmo;
                spi_we_o  = m0_we_i;
                spi_dat_o = m0_dat_i;
                m0_ack_o  = spi_ack_i || tmo;
                if (tmo)
                    m0_dat_o = '1;
                else if (spi_ack_i)
                    m0_dat_o = spi_dat_i;
            end
            G1: begin
                spi_adr_o = m1_adr_i;
                spi_sel_o = m1_sel_i;
                spi_stb_o = m1_stb_i && !tmo;
                spi_we_o  = m1_we_i;
                spi_dat_o = m1_dat_i;
                m1_ack_o  = spi_ack_i || tmo;
                if (tmo)
                    m1_dat_o = '1;
                else if (spi_ack_i)
                    m1_dat_o = spi_dat_i;
            end
            default: ;
        endcase
    end

    assign grant_o = {state == G1, state == G0};

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// Directed self-checking bench for spi_wb_arbiter (TIMEOUT overridden to 8).
module tb_spi_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:2]  m0_adr_i, m1_adr_i, spi_adr_o;
    logic [3:0]  m0_sel_i, m1_sel_i, spi_sel_o;
    logic        m0_stb_i, m1_stb_i, m0_we_i, m1_we_i, m0_lock_i, m1_lock_i;
    logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, spi_dat_o, spi_dat_i;
    logic        m0_ack_o, m1_ack_o, spi_stb_o, spi_we_o, spi_ack_i;
    logic [1:0]  grant_o;

    int n_checks = 0;
    int n_fail   = 0;

    spi_wb_arbiter #(.TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i),
        .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i), .m0_lock_i(m0_lock_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
        .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i), .m1_lock_i(m1_lock_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .spi_adr_o(spi_adr_o), .spi_sel_o(spi_sel_o), .spi_stb_o(spi_stb_o),
        .spi_we_o(spi_we_o), .spi_dat_o(spi_dat_o), .spi_dat_i(spi_dat_i),
        .spi_ack_i(spi_ack_i), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        m0_adr_i = '0; m0_sel_i = 4'hF; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m0_dat_i = 32'h0BAD_0000; m0_lock_i = 1'b0;
        m1_adr_i = '0; m1_sel_i = 4'hF; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m1_dat_i = 32'h0BAD_1111; m1_lock_i = 1'b0;
        spi_dat_i = 32'hDEAD_BEEF; spi_ack_i = 1'b0;
        step;
        step;
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        n_checks++; if (spi_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b expected 0", spi_stb_o); end
        n_checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", {m0_ack_o, m1_ack_o}); end
        n_checks++; if (spi_dat_o !== 32'h0 || spi_adr_o !== 2'b00 || spi_sel_o !== 4'h0 || spi_we_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_spi_out: got dat %h adr %b sel %h we %b expected all 0", spi_dat_o, spi_adr_o, spi_sel_o, spi_we_o); end
        n_checks++; if (m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_mdat: got %h %h expected 0 0", m0_dat_o, m1_dat_o); end
    endtask

    task automatic test_single;
        do_reset;
        m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 2'd2; m0_dat_i = 32'hA5A5_0001;
        #1;
        n_checks++; if (grant_o !== 2'b00 || spi_stb_o !== 1'b0) begin n_fail++; $display("FAIL single_c0: got grant %b stb %b expected 00 0", grant_o, spi_stb_o); end
        step;
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", grant_o); end
        n_checks++; if (spi_stb_o !== 1'b1 || spi_dat_o !== 32'hA5A5_0001 || spi_adr_o !== 2'd2 || spi_we_o !== 1'b1) begin
            n_fail++; $display("FAIL single_fwd: got stb %b dat %h adr %0d we %b expected 1 a5a50001 2 1", spi_stb_o, spi_dat_o, spi_adr_o, spi_we_o); end
        n_checks++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_early_ack: got %b expected 0", m0_ack_o); end
        spi_ack_i = 1'b1; spi_dat_i = 32'h1234_5678;
        #1;
        n_checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_dat_o !== 32'h1234_5678) begin
            n_fail++; $display("FAIL single_ack: got m0_ack %b m1_ack %b m0_dat %h expected 1 0 12345678", m0_ack_o, m1_ack_o, m0_dat_o); end
        step;
        n_checks++; if (grant_o !== 2'b00 || spi_stb_o !== 1'b0) begin n_fail++; $display("FAIL single_release: got grant %b stb %b expected 00 0", grant_o, spi_stb_o); end
        m0_stb_i = 1'b0; spi_ack_i = 1'b0;
    endtask

    task automatic test_tie;
        logic [1:0] exp_g [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        logic [31:0] d;
        do_reset;
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step;
            spi_ack_i = 1'b0;
            #1;
            n_checks++; if (grant_o !== exp_g[i]) begin n_fail++; $display("FAIL tie_grant[%0d]: got %b expected %b", i, grant_o, exp_g[i]); end
            if (exp_g[i] != 2'b00) begin
                d = 32'hC0DE_0000 + 32'(i);
                spi_ack_i = 1'b1; spi_dat_i = d;
                #1;
                if (exp_g[i] == 2'b01) begin
                    n_checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== d || m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin
                        n_fail++; $display("FAIL tie_ack[%0d]: got m0 %b/%h m1 %b/%h expected m0 1/%h m1 0/0", i, m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o, d); end
                end else begin
                    n_checks++; if (m1_ack_o !== 1'b1 || m1_dat_o !== d || m0_ack_o !== 1'b0 || m0_dat_o !== 32'h0) begin
                        n_fail++; $display("FAIL tie_ack[%0d]: got m0 %b/%h m1 %b/%h expected m0 0/0 m1 1/%h", i, m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o, d); end
                end
            end
        end
        step;
        m0_stb_i = 1'b0; m1_stb_i = 1'b0; spi_ack_i = 1'b0;
    endtask

    task automatic test_lock;
        logic [31:0] d;
        do_reset;
        m1_stb_i = 1'b1; m1_lock_i = 1'b1; m1_we_i = 1'b0;
        step;
        m0_stb_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = 32'h5000_0000 + 32'(k);
            m1_adr_i = 2'(k); spi_ack_i = 1'b1; spi_dat_i = d;
            #1;
            n_checks++; if (grant_o !== 2'b10 || spi_stb_o !== 1'b1 || spi_adr_o !== 2'(k)) begin
                n_fail++; $display("FAIL lock_xfer[%0d]: got grant %b stb %b adr %0d expected 10 1 %0d", k, grant_o, spi_stb_o, spi_adr_o, k); end
            n_checks++; if (m1_ack_o !== 1'b1 || m1_dat_o !== d || m0_ack_o !== 1'b0) begin
                n_fail++; $display("FAIL lock_ack[%0d]: got m1 %b/%h m0_ack %b expected 1/%h 0", k, m1_ack_o, m1_dat_o, m0_ack_o, d); end
            step;
            spi_ack_i = 1'b0;
            #1;
            n_checks++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL lock_hold[%0d]: got %b expected 10", k, grant_o); end
        end
        m1_stb_i = 1'b0; m1_lock_i = 1'b0;
        #1;
        n_checks++; if (spi_stb_o !== 1'b0 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL lock_drop: got stb %b m0_ack %b expected 0 0", spi_stb_o, m0_ack_o); end
        step;
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL lock_idle: got %b expected 00", grant_o); end
        step;
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL lock_next_m0: got %b expected 01", grant_o); end
        spi_ack_i = 1'b1;
        step;
        spi_ack_i = 1'b0; m0_stb_i = 1'b0;
    endtask

    task automatic test_abort_reset;
        do_reset;
        m0_stb_i = 1'b1;
        step;
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL abort_grant: got %b expected 01", grant_o); end
        m0_stb_i = 1'b0;
        #1;
        n_checks++; if (m0_ack_o !== 1'b0 || spi_stb_o !== 1'b0) begin n_fail++; $display("FAIL abort_noack: got ack %b stb %b expected 0 0", m0_ack_o, spi_stb_o); end
        step;
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got %b expected 00", grant_o); end
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        step;
        n_checks++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL abort_prio: got %b expected 10", grant_o); end
        rst_i = 1'b1;
        step;
        n_checks++; if (grant_o !== 2'b00 || spi_stb_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got grant %b stb %b m1_ack %b expected 00 0 0", grant_o, spi_stb_o, m1_ack_o); end
        rst_i = 1'b0;
        step;
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL reset_prio: got %b expected 01", grant_o); end
        m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        step;
    endtask

    task automatic test_timeout;
        int acks = 0, stb_cycles = 0;
        logic [31:0] ack_dat = '0;
        logic ack_stb = 1'b1, seen_prev = 1'b0;
        logic [1:0] grant_after = 2'b11;
        do_reset;
        m1_stb_i = 1'b1; m1_we_i = 1'b0;
        step;
        for (int c = 0; c < 20; c++) begin
            if (seen_prev) begin grant_after = grant_o; seen_prev = 1'b0; end
            if (m1_ack_o === 1'b1) begin
                acks++; ack_dat = m1_dat_o; ack_stb = spi_stb_o; seen_prev = 1'b1;
                m1_stb_i = 1'b0;
            end else if (acks == 0 && spi_stb_o === 1'b1) begin
                stb_cycles++;
            end
            step;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL tmo_ack_count: got %0d expected 1", acks); end
        n_checks++; if (stb_cycles != 8) begin n_fail++; $display("FAIL tmo_latency: got %0d strobed cycles expected 8", stb_cycles); end
        n_checks++; if (ack_dat !== 32'hFFFF_FFFF || ack_stb !== 1'b0) begin n_fail++; $display("FAIL tmo_ack_data: got dat %h stb %b expected ffffffff 0", ack_dat, ack_stb); end
        n_checks++; if (grant_after !== 2'b00) begin n_fail++; $display("FAIL tmo_release: got %b expected 00", grant_after); end
`else
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL notmo_ack_count: got %0d expected 0", acks); end
        n_checks++; if (grant_o !== 2'b10 || spi_stb_o !== 1'b1) begin n_fail++; $display("FAIL notmo_hold: got grant %b stb %b expected 10 1", grant_o, spi_stb_o); end
`endif
        m1_stb_i = 1'b0;
        do_reset;
    endtask

    initial begin
        test_reset;
        test_single;
        test_tie;
        test_lock;
        test_abort_reset;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
